// File: rtl/tx_frame_pkg.sv
// tx_frame_pkg: shared FSM state type and frame-width helper for tx_frame_ctrl.
// Parity support is selected at compile time with TX_PARITY_EN.
package tx_frame_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, SEND} state_e;
`ifdef TX_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif
    function automatic int frame_bits(input int data_bits, input bit parity);
        return data_bits + (parity ? 3 : 2);
    endfunction
endpackage

// File: rtl/tx_fifo.sv
// tx_fifo: synchronous FIFO with wrap-bit pointers; rdata always shows the head entry.
module tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [AW:0] wr_q, wr_d, rd_q, rd_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic do_push, do_pop;
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty = wr_q == rd_q;
    assign rdata = mem_q[rd_q[AW-1:0]];
    always_comb begin
        do_push = push && !full;
        do_pop  = pop && !empty;
        wr_d    = do_push ? wr_q + {{AW{1'b0}}, 1'b1} : wr_q;
        rd_d    = do_pop ? rd_q + {{AW{1'b0}}, 1'b1} : rd_q;
        mem_d   = mem_q;
        if (do_push) mem_d[wr_q[AW-1:0]] = wdata;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end
    always_ff @(posedge clk) mem_q <= mem_d;
endmodule

// File: rtl/tx_frame_ctrl.sv
// tx_frame_ctrl: queues words and sequences a start/data/(parity)/stop frame into a
// downstream MSB-first shift register. Define TX_PARITY_EN for an even-parity bit.
module tx_frame_ctrl import tx_frame_pkg::*; #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_DEPTH   = 4,
    localparam int FRAME_BITS  = frame_bits(DATA_BITS, PARITY_EN)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_BITS-1:0]  tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [FRAME_BITS-1:0] parallel_out,
    output logic                  load_enable,
    output logic                  shift_enable,
    output logic                  busy,
    output logic                  frame_done
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(FRAME_BITS);
    localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS - 1);
    state_e state_q, state_d;
    logic [CW-1:0] clk_cnt_q, clk_cnt_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] head;
    logic [FRAME_BITS-1:0] frame;
    logic full, empty, pop;
    tx_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_valid),
        .pop   (pop),
        .wdata (tx_data),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );
    assign tx_ready     = !full;
    assign busy         = state_q != IDLE;
    assign parallel_out = empty ? '1 : frame;
    // Start bit at the MSB, data LSB-first behind it, stop bit at bit 0.
    always_comb begin
        frame = '1;
        frame[FRAME_BITS-1] = 1'b0;
        for (int k = 0; k < DATA_BITS; k++) frame[FRAME_BITS-2-k] = head[k];
`ifdef TX_PARITY_EN
        frame[1] = ^head;
`endif
    end
    always_comb begin
        state_d      = state_q;
        clk_cnt_d    = clk_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        load_enable  = 1'b0;
        shift_enable = 1'b0;
        frame_done   = 1'b0;
        pop          = 1'b0;
        case (state_q)
            IDLE: state_d = empty ? IDLE : LOAD;
            LOAD: begin
                load_enable = 1'b1;
                pop         = 1'b1;
                clk_cnt_d   = '0;
                bit_cnt_d   = '0;
                state_d     = SEND;
            end
            SEND: begin
                clk_cnt_d = clk_cnt_q + CW'(1);
                if (clk_cnt_q == CLK_LAST) begin
                    clk_cnt_d = '0;
                    if (bit_cnt_q < BIT_LAST) begin
                        shift_enable = 1'b1;
                        bit_cnt_d    = bit_cnt_q + BW'(1);
                    end else begin
                        // Stop bit stays on the line; the shift register holds it while idle.
                        frame_done = 1'b1;
                        bit_cnt_d  = '0;
                        state_d    = empty ? IDLE : LOAD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end
endmodule

// File: tb/tb_tx_frame_ctrl.sv
// tb_tx_frame_ctrl: scoreboard bench; models the downstream shift register and the
// frame timeline, and checks framing, line bits, strobes and handshake every cycle.
module tb_tx_frame_ctrl;
    localparam int DB = 8;
    localparam int C  = 4;
    localparam int DEPTH = 4;
`ifdef TX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int FB = DB + (PAR ? 3 : 2);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [DB-1:0] tx_data = '0;
    logic tx_valid = 1'b0;
    logic tx_ready, load_enable, shift_enable, busy, frame_done;
    logic [FB-1:0] parallel_out;

    tx_frame_ctrl #(.DATA_BITS(DB), .CLKS_PER_BIT(C), .FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .parallel_out (parallel_out),
        .load_enable  (load_enable),
        .shift_enable (shift_enable),
        .busy         (busy),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic fbit(input logic [DB-1:0] w, input int i);
        if (i == 0) return 1'b0;
        if (i <= DB) return w[i-1];
        if (PAR && i == DB + 1) return ^w;
        return 1'b1;
    endfunction

    function automatic logic [FB-1:0] fvec(input logic [DB-1:0] w);
        logic [FB-1:0] v;
        for (int i = 0; i < FB; i++) v[FB-1-i] = fbit(w, i);
        return v;
    endfunction

    // Downstream MSB-first shift register that turns the strobes into a line.
    logic [FB-1:0] sr;
    always @(posedge clk or posedge rst) begin
        if (rst) sr <= '1;
        else if (load_enable) sr <= parallel_out;
        else if (shift_enable) sr <= {sr[FB-2:0], 1'b1};
    end

    logic [DB-1:0] q[$];
    logic [DB-1:0] cur;
    int t = 0;
    int sz;
    bit load_next = 0;
    bit exp_load, exp_shift, exp_done;

    always @(negedge clk) begin
        sz = q.size();
        if (rst) begin
            q.delete();
            t = 0;
            load_next = 0;
            chk("rst_load", load_enable, 0);
            chk("rst_shift", shift_enable, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", frame_done, 0);
            chk("rst_ready", tx_ready, 1);
        end else begin
            exp_load  = load_next;
            exp_shift = t > 0 && t % C == 0 && t < FB * C;
            exp_done  = t == FB * C;
            chk("load_enable", load_enable, exp_load);
            chk("shift_enable", shift_enable, exp_shift);
            chk("frame_done", frame_done, exp_done);
            chk("busy", busy, exp_load || t > 0);
            chk("tx_ready", tx_ready, sz < DEPTH);
            if (sz == 0) chk("empty_parallel", parallel_out, {FB{1'b1}});
            if (t > 0) chk("line_bit", sr[FB-1], fbit(cur, (t - 1) / C));
            else if (!exp_load) chk("line_idle", sr[FB-1], 1);
            if (exp_load && sz > 0) begin
                cur = q.pop_front();
                chk("frame_vec", parallel_out, fvec(cur));
                if (cur == 8'hA5) chk("vec_a5", parallel_out, PAR ? 32'b0_10100101_0_1 : 32'b0_10100101_1);
                if (cur == 8'h07) chk("vec_07", parallel_out, PAR ? 32'b0_11100000_1_1 : 32'b0_11100000_1);
            end
            if (tx_valid && tx_ready) q.push_back(tx_data);
            if (exp_load) begin
                t = 1;
                load_next = 0;
            end else if (t > 0 && t < FB * C) t++;
            else begin
                t = 0;
                load_next = sz > 0;
            end
        end
    end

    task automatic push_word(input logic [DB-1:0] w);
        int n = 0;
        @(posedge clk); #2;
        tx_valid = 1'b1;
        tx_data  = w;
        @(negedge clk);
        while (!tx_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) chk("push_timeout", 0, 1);
        @(posedge clk); #2;
        tx_valid = 1'b0;
    endtask

    task automatic wait_load();
        int n = 0;
        @(negedge clk);
        while (!load_enable && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) chk("load_timeout", 0, 1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((q.size() != 0 || busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) chk("drain_timeout", 0, 1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        push_word(8'hA5);
        wait_drain();
        push_word(8'h00);
        push_word(8'hFF);
        wait_drain();
        push_word(8'h07);
        wait_load();
        for (int i = 0; i < 5; i++) push_word(8'h10 + 8'(i));
        wait_drain();
        push_word(8'h3C);
        push_word(8'h11);
        push_word(8'h22);
        wait_load();
        repeat (3 * C + 2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("async_load", load_enable, 0);
        chk("async_shift", shift_enable, 0);
        chk("async_busy", busy, 0);
        chk("async_done", frame_done, 0);
        chk("async_ready", tx_ready, 1);
        chk("async_parallel", parallel_out, {FB{1'b1}});
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        repeat (60) @(negedge clk);
        chk("no_load_after_rst", busy, 0);
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #2;
            tx_valid = $urandom_range(0, 3) == 0;
            tx_data  = DB'($urandom);
        end
        @(posedge clk); #2;
        tx_valid = 1'b0;
        wait_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
